mem_access_stage: RTL

- Memory-access stage that sits directly downstream of the execute stage in the non-pipelined LEGv8 datapath.
- Consumes the ALU result (as the effective address), read_data2 (as store data), the branch target and the registered NZCV flags.
- Runs a multi-cycle request/acknowledge transaction with the data memory, aligns sub-doubleword loads and stores, and stalls the core until the access completes.
- Resolves the branch decision (pc_src) for the fetch stage.

---
 rtl/mem_access_stage_pkg.sv | 56 +++++
 rtl/mem_lane_align.sv | 35 +++
 rtl/mem_access_stage.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared codes, state encoding and helpers for the memory-access stage
package mem_access_stage_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;
    localparam logic [1:0] MEM_SIZE_D = 2'b11;

    localparam logic [1:0] BR_CBZ  = 2'b00;
    localparam logic [1:0] BR_CBNZ = 2'b01;
    localparam logic [1:0] BR_COND = 2'b10;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_BUSY = 2'b01,
        MS_DONE = 2'b10
    } ms_state_t;

    // Byte-lane mask for an access of the given size, before positioning.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            MEM_SIZE_B: size_mask = 8'h01;
            MEM_SIZE_H: size_mask = 8'h03;
            MEM_SIZE_W: size_mask = 8'h0F;
            default:    size_mask = 8'hFF;
        endcase
    endfunction

    // Natural alignment: the low address bits below the access size must be zero.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lo);
        case (size)
            MEM_SIZE_H: is_misaligned = lo[0];
            MEM_SIZE_W: is_misaligned = |lo[1:0];
            MEM_SIZE_D: is_misaligned = |lo;
            default:    is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian byte-enable, store shift and load extract
module mem_lane_align
    import mem_access_stage_pkg::*;
#(
    parameter int WORD = 64
) (
    input  logic [2:0]      i_addr_lo,
    input  logic [1:0]      i_size,
    input  logic [WORD-1:0] i_store_data,
    input  logic [WORD-1:0] i_mem_rdata,
    output logic [7:0]      o_be,
    output logic [WORD-1:0] o_wdata,
    output logic [WORD-1:0] o_rdata
);

    logic [5:0]      w_sh;
    logic [WORD-1:0] w_rd_shifted;

    assign w_sh         = {i_addr_lo, 3'b000};
    assign o_be         = size_mask(i_size) << i_addr_lo;
    assign o_wdata      = i_store_data << w_sh;
    assign w_rd_shifted = i_mem_rdata >> w_sh;

    // Keep only the bytes of the access and zero-extend to the full width.
    always_comb begin
        o_rdata = '0;
        case (i_size)
            MEM_SIZE_B: o_rdata[7:0]  = w_rd_shifted[7:0];
            MEM_SIZE_H: o_rdata[15:0] = w_rd_shifted[15:0];
            MEM_SIZE_W: o_rdata[31:0] = w_rd_shifted[31:0];
            default:    o_rdata       = w_rd_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - LEGv8 memory-access stage: bus transaction FSM, timeout and branch resolve
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int WORD    = 64,
    parameter int TIMEOUT = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [WORD-1:0] i_alu_result,
    input  logic [WORD-1:0] i_write_data,
    input  logic [WORD-1:0] i_branch_alu_result,
    input  logic            i_mem_read,
    input  logic            i_mem_write,
    input  logic [1:0]      i_mem_size,
    input  logic            i_branch,
    input  logic            i_uncond_branch,
    input  logic [1:0]      i_branch_type,
    input  logic [3:0]      i_cond,
    input  logic            i_zero,
    input  logic            i_negative,
    input  logic            i_overflow,
    input  logic            i_carry,
    input  logic [WORD-1:0] i_dmem_rdata,
    input  logic            i_dmem_ack,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [WORD-1:0] o_dmem_addr,
    output logic [WORD-1:0] o_dmem_wdata,
    output logic [7:0]      o_dmem_be,
    output logic [WORD-1:0] o_read_data,
    output logic            o_stall,
    output logic            o_fault,
    output logic            o_pc_src,
    output logic [WORD-1:0] o_branch_target
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    ms_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_fault;
    logic [WORD-1:0] r_read_data;

    logic            w_access;
    logic            w_misaligned;
    logic [7:0]      w_be;
    logic [WORD-1:0] w_wdata;
    logic [WORD-1:0] w_rdata;
    logic            w_taken;
    logic            w_cond_true;

    assign w_access     = i_mem_read | i_mem_write;
    assign w_misaligned = is_misaligned(i_mem_size, i_alu_result[2:0]);

    mem_lane_align #(.WORD(WORD)) u_align (
        .i_addr_lo    (i_alu_result[2:0]),
        .i_size       (i_mem_size),
        .i_store_data (i_write_data),
        .i_mem_rdata  (i_dmem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_rdata      (w_rdata)
    );

    // Transaction FSM: launch in IDLE, wait for ack or timeout in BUSY, present the result in DONE.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= MS_IDLE;
            r_cnt        <= '0;
            r_fault      <= 1'b0;
            r_read_data  <= '0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_wdata <= '0;
            o_dmem_be    <= '0;
        end else begin
            case (r_state)
                MS_IDLE: begin
                    if (w_access && !w_misaligned) begin
                        r_state      <= MS_BUSY;
                        r_cnt        <= '0;
                        o_dmem_req   <= 1'b1;
                        o_dmem_we    <= i_mem_write;
                        o_dmem_addr  <= {i_alu_result[WORD-1:3], 3'b000};
                        o_dmem_wdata <= w_wdata;
                        o_dmem_be    <= w_be;
                    end
                end
                MS_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (i_dmem_ack) begin
                        o_dmem_req  <= 1'b0;
                        r_read_data <= o_dmem_we ? '0 : w_rdata;
                        r_state     <= MS_DONE;
                    end else if (r_cnt == LAST_CNT) begin
                        o_dmem_req  <= 1'b0;
                        r_read_data <= '0;
                        r_fault     <= 1'b1;
                        r_state     <= MS_DONE;
                    end
                end
                default: begin
                    r_fault <= 1'b0;
                    r_state <= MS_IDLE;
                end
            endcase
        end
    end

    // Stall from the moment an aligned access appears until the cycle the result is presented.
    always_comb begin
        o_stall = 1'b0;
        case (r_state)
            MS_IDLE: o_stall = w_access & ~w_misaligned;
            MS_BUSY: o_stall = 1'b1;
            default: o_stall = 1'b0;
        endcase
        if (i_reset) o_stall = 1'b0;
    end

    assign o_fault     = ~i_reset & (r_fault | ((r_state == MS_IDLE) & w_access & w_misaligned));
    assign o_read_data = r_read_data;

    // AArch64 condition evaluation on the registered flags; NV behaves as AL.
    always_comb begin
        w_cond_true = 1'b0;
        case (i_cond)
            COND_EQ: w_cond_true = i_zero;
            COND_NE: w_cond_true = ~i_zero;
            COND_CS: w_cond_true = i_carry;
            COND_CC: w_cond_true = ~i_carry;
            COND_MI: w_cond_true = i_negative;
            COND_PL: w_cond_true = ~i_negative;
            COND_VS: w_cond_true = i_overflow;
            COND_VC: w_cond_true = ~i_overflow;
            COND_HI: w_cond_true = i_carry & ~i_zero;
            COND_LS: w_cond_true = ~i_carry | i_zero;
            COND_GE: w_cond_true = (i_negative == i_overflow);
            COND_LT: w_cond_true = (i_negative != i_overflow);
            COND_GT: w_cond_true = ~i_zero & (i_negative == i_overflow);
            COND_LE: w_cond_true = i_zero | (i_negative != i_overflow);
            COND_AL: w_cond_true = 1'b1;
            COND_NV: w_cond_true = 1'b1;
            default: w_cond_true = 1'b0;
        endcase
    end

    // Branch decision by type; the reserved type is never taken.
    always_comb begin
        w_taken = 1'b0;
        case (i_branch_type)
            BR_CBZ:  w_taken = (i_alu_result == '0);
            BR_CBNZ: w_taken = (i_alu_result != '0);
            BR_COND: w_taken = w_cond_true;
            default: w_taken = 1'b0;
        endcase
    end

    assign o_pc_src        = i_uncond_branch | (i_branch & w_taken);
    assign o_branch_target = i_branch_alu_result;

endmodule
